// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter merging NUM_REQ valid/ready/last packet streams into one
// registered output stage; a grant is held for a whole packet.
module rr_reg_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 64,
   localparam int IDW    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_last,
   output logic [IDW-1:0]             out_id,
   input  logic                       out_ready
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] LOCK = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [IDW-1:0]   cur_q, cur_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_last_q, out_last_d;
   logic [IDW-1:0]   out_id_q, out_id_d;

   logic             can_load, any_valid, found, grant_en, xfer;
   logic [IDW-1:0]   rr_sel, sel;
   logic [WIDTH-1:0] sel_data;

   // Nearest valid requester after rr_ptr, wrapping around.
   always_comb begin
      int idx;
      idx    = 0;
      rr_sel = '0;
      found  = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            rr_sel = IDW'(idx);
         end
      end
   end

   assign any_valid = |req_valid;
   assign can_load  = !out_valid_q | out_ready;
   assign sel       = (state_q == LOCK) ? cur_q : rr_sel;
   // Ready is suppressed while in reset so nothing is accepted and then dropped.
   assign grant_en  = !rst & can_load & ((state_q == LOCK) | any_valid);
   assign req_ready = grant_en ? (NUM_REQ'(1) << sel) : '0;
   assign xfer      = grant_en & req_valid[sel];
   assign sel_data  = req_data[int'(sel)*WIDTH +: WIDTH];

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      rr_ptr_d    = rr_ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_id_d    = out_id_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data;
         out_last_d  = req_last[sel];
         out_id_d    = sel;
         if (req_last[sel]) begin
            state_d  = IDLE;
            rr_ptr_d = sel;
         end else if (state_q == IDLE) begin
            state_d = LOCK;
            cur_d   = sel;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cur_q       <= '0;
         rr_ptr_q    <= IDW'(NUM_REQ - 1);
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_id_q    <= out_id_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_id    = out_id_q;

endmodule
